// File: rtl/hub75_fb_pkg.sv
// Shared types and helpers for the HUB75 framebuffer write-side sequencer.
// Holds the FSM state encoding and the counter terminal-value compare.
package hub75_fb_pkg;

   typedef enum logic [2:0] {
      FILL       = 3'd0,
      WAIT_RDY   = 3'd1,
      SWAP       = 3'd2,
      STORE      = 3'd3,
      GUARD      = 3'd4,
      FRAME_WAIT = 3'd5,
      FRAME_SWAP = 3'd6
   } fb_state_t;

   // Exact terminal compare, so counts that are not powers of two wrap correctly.
   function automatic logic at_last(input int value, input int count);
      return value == (count - 1);
   endfunction

   // Address width that never collapses to zero bits for a single-entry dimension.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hub75_fb_raster_cnt.sv
// Raster position counters (col fastest, then row, then bank) for the write side.
// A clear combined with inc_col restarts at column 1 of line 0 for a restarting pixel.
module hub75_fb_raster_cnt
   import hub75_fb_pkg::*;
#(
   parameter int N_BANKS     = 2,
   parameter int N_ROWS      = 32,
   parameter int N_COLS      = 64,
   parameter int LOG_N_BANKS = clog2_min1(N_BANKS),
   parameter int LOG_N_ROWS  = clog2_min1(N_ROWS),
   parameter int LOG_N_COLS  = clog2_min1(N_COLS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   inc_col,
   input  logic                   inc_line,
   output logic [LOG_N_COLS-1:0]  col,
   output logic [LOG_N_ROWS-1:0]  row,
   output logic [LOG_N_BANKS-1:0] bank,
   output logic                   at_origin,
   output logic                   last_col,
   output logic                   last_line
);

   logic last_row;
   logic last_bank;

   assign last_col  = at_last(int'(col), N_COLS);
   assign last_row  = at_last(int'(row), N_ROWS);
   assign last_bank = at_last(int'(bank), N_BANKS);
   assign last_line = last_row & last_bank;
   assign at_origin = (col == '0) && (row == '0) && (bank == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col  <= '0;
         row  <= '0;
         bank <= '0;
      end else if (clear) begin
         row  <= '0;
         bank <= '0;
         col  <= (inc_col && (N_COLS > 1)) ? LOG_N_COLS'(1) : '0;
      end else begin
         if (inc_col) begin
            col <= last_col ? '0 : col + 1'b1;
         end
         if (inc_line) begin
            if (last_row) begin
               row  <= '0;
               bank <= last_bank ? '0 : bank + 1'b1;
            end else begin
               row <= row + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/hub75_fb_stream_writer.sv
// Write-side initiator: takes a raster pixel stream and drives column writes,
// line-buffer swap/store per row and a frame flip once per completed frame.
module hub75_fb_stream_writer
   import hub75_fb_pkg::*;
#(
   parameter int N_BANKS     = 2,
   parameter int N_ROWS      = 32,
   parameter int N_COLS      = 64,
   parameter int BITDEPTH    = 24,
   parameter int LOG_N_BANKS = clog2_min1(N_BANKS),
   parameter int LOG_N_ROWS  = clog2_min1(N_ROWS),
   parameter int LOG_N_COLS  = clog2_min1(N_COLS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [BITDEPTH-1:0]    in_data,
   input  logic                   in_sof,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   cfg_swap_en,
   output logic [LOG_N_BANKS-1:0] wr_bank_addr,
   output logic [LOG_N_ROWS-1:0]  wr_row_addr,
   output logic                   wr_row_store,
   input  logic                   wr_row_rdy,
   output logic                   wr_row_swap,
   output logic [BITDEPTH-1:0]    wr_data,
   output logic [LOG_N_COLS-1:0]  wr_col_addr,
   output logic                   wr_en,
   output logic                   frame_swap,
   output logic                   frame_done,
   output logic                   err_sof,
   output logic [2:0]             dbg_state
);

   // Handshake: a pixel transfers on a rising clk edge where in_valid & in_ready.
   // in_ready depends on FSM state only, so the source may hold in_valid and
   // in_data stable indefinitely without the sink ever dropping the word.

   fb_state_t state;
   fb_state_t state_next;

   logic [LOG_N_COLS-1:0]  col;
   logic [LOG_N_ROWS-1:0]  row;
   logic [LOG_N_BANKS-1:0] bank;
   logic                   at_origin;
   logic                   last_col;
   logic                   last_line;

   logic accept;
   logic sof_err;
   logic cnt_clear;
   logic cnt_inc_col;
   logic cnt_inc_line;

   assign in_ready  = (state == FILL);
   assign accept    = in_valid & in_ready;
   assign sof_err   = accept & in_sof & ~at_origin;
   assign dbg_state = state;

   // Counters only move at the end of STORE, so the address is steady through SWAP and STORE.
   assign wr_bank_addr = bank;
   assign wr_row_addr  = row;

   hub75_fb_raster_cnt #(
      .N_BANKS     (N_BANKS),
      .N_ROWS      (N_ROWS),
      .N_COLS      (N_COLS),
      .LOG_N_BANKS (LOG_N_BANKS),
      .LOG_N_ROWS  (LOG_N_ROWS),
      .LOG_N_COLS  (LOG_N_COLS)
   ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .clear     (cnt_clear),
      .inc_col   (cnt_inc_col),
      .inc_line  (cnt_inc_line),
      .col       (col),
      .row       (row),
      .bank      (bank),
      .at_origin (at_origin),
      .last_col  (last_col),
      .last_line (last_line)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FILL;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next   = state;
      cnt_clear    = 1'b0;
      cnt_inc_col  = 1'b0;
      cnt_inc_line = 1'b0;
      case (state)
         FILL: begin
            if (accept) begin
               cnt_inc_col = 1'b1;
               // A stray start-of-frame abandons the partial line and restarts at col 0.
               if (sof_err) begin
                  cnt_clear = 1'b1;
                  if (N_COLS == 1) begin
                     state_next = WAIT_RDY;
                  end
               end else if (last_col) begin
                  state_next = WAIT_RDY;
               end
            end
         end
         WAIT_RDY: begin
            if (wr_row_rdy) begin
               state_next = SWAP;
            end
         end
         SWAP: begin
            state_next = STORE;
         end
         STORE: begin
            if (last_line) begin
               state_next = GUARD;
            end else begin
               cnt_inc_line = 1'b1;
               state_next   = FILL;
            end
         end
         GUARD: begin
            state_next = FRAME_WAIT;
         end
         FRAME_WAIT: begin
            if (wr_row_rdy) begin
               state_next = FRAME_SWAP;
            end
         end
         FRAME_SWAP: begin
            cnt_clear  = 1'b1;
            state_next = FILL;
         end
         default: begin
            state_next = FILL;
         end
      endcase
   end

   // Pulses are registered from the next state so they line up with the state they belong to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en        <= 1'b0;
         wr_col_addr  <= '0;
         wr_data      <= '0;
         err_sof      <= 1'b0;
         wr_row_swap  <= 1'b0;
         wr_row_store <= 1'b0;
         frame_done   <= 1'b0;
         frame_swap   <= 1'b0;
      end else begin
         wr_en        <= accept;
         err_sof      <= sof_err;
         wr_row_swap  <= (state_next == SWAP);
         wr_row_store <= (state_next == STORE);
         frame_done   <= (state_next == FRAME_SWAP);
         frame_swap   <= (state_next == FRAME_SWAP) & cfg_swap_en;
         if (accept) begin
            wr_col_addr <= sof_err ? '0 : col;
            wr_data     <= in_data;
         end
      end
   end

endmodule

// File: tb/tb_hub75_fb_stream_writer.sv
// Directed bench for hub75_fb_stream_writer on a 2x4x8 panel with 16-bit pixels:
// table-driven full frames plus hand-written stall, stray-SOF and mid-line reset sequences.
module tb_hub75_fb_stream_writer;

   localparam int NB = 2;
   localparam int NR = 4;
   localparam int NC = 8;
   localparam int BD = 16;
   localparam int LINES = NB * NR;
   localparam int PIX = LINES * NC;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [BD-1:0] in_data;
   logic          in_sof;
   logic          in_valid;
   logic          in_ready;
   logic          cfg_swap_en;
   logic [0:0]    wr_bank_addr;
   logic [1:0]    wr_row_addr;
   logic          wr_row_store;
   logic          wr_row_rdy;
   logic          wr_row_swap;
   logic [BD-1:0] wr_data;
   logic [2:0]    wr_col_addr;
   logic          wr_en;
   logic          frame_swap;
   logic          frame_done;
   logic          err_sof;
   logic [2:0]    dbg_state;

   hub75_fb_stream_writer #(
      .N_BANKS  (NB),
      .N_ROWS   (NR),
      .N_COLS   (NC),
      .BITDEPTH (BD)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_sof       (in_sof),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .cfg_swap_en  (cfg_swap_en),
      .wr_bank_addr (wr_bank_addr),
      .wr_row_addr  (wr_row_addr),
      .wr_row_store (wr_row_store),
      .wr_row_rdy   (wr_row_rdy),
      .wr_row_swap  (wr_row_swap),
      .wr_data      (wr_data),
      .wr_col_addr  (wr_col_addr),
      .wr_en        (wr_en),
      .frame_swap   (frame_swap),
      .frame_done   (frame_done),
      .err_sof      (err_sof),
      .dbg_state    (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_bad = 0;

   logic [18:0] wr_q[$];
   logic [18:0] exp_q[$];
   logic [2:0]  st_q[$];
   logic [2:0]  exp_st_q[$];
   int          gap_q[$];
   int swap_cnt, fswap_cnt, fdone_cnt, err_cnt, overlap_cnt, low_run;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (wr_en) wr_q.push_back({wr_col_addr, wr_data});
         if (wr_row_store) st_q.push_back({wr_bank_addr, wr_row_addr});
         if (wr_row_swap) swap_cnt++;
         if (wr_row_swap && wr_row_store) overlap_cnt++;
         if (frame_swap) fswap_cnt++;
         if (frame_done) fdone_cnt++;
         if (err_sof) err_cnt++;
         if (!in_ready) low_run++;
         else begin
            if (low_run > 0) gap_q.push_back(low_run);
            low_run = 0;
         end
      end
   end

   task automatic clear_mon();
      wr_q.delete(); exp_q.delete(); st_q.delete(); exp_st_q.delete(); gap_q.delete();
      swap_cnt = 0; fswap_cnt = 0; fdone_cnt = 0; err_cnt = 0; overlap_cnt = 0; low_run = 0;
   endtask

   task automatic exp_frame(input int base, input int first);
      for (int i = first; i < PIX; i++) exp_q.push_back({3'(i % NC), 16'(base + i)});
      for (int l = 0; l < LINES; l++) exp_st_q.push_back(3'(l));
   endtask

   task automatic compare_all(input string tag);
      check({tag, "_wr_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
         check({tag, "_wr_seq"}, 32'(wr_q[i]), 32'(exp_q[i]));
      check({tag, "_store_count"}, 32'(st_q.size()), 32'(exp_st_q.size()));
      for (int i = 0; i < exp_st_q.size() && i < st_q.size(); i++)
         check({tag, "_store_addr"}, 32'(st_q[i]), 32'(exp_st_q[i]));
      check({tag, "_swap_store_overlap"}, 32'(overlap_cnt), 0);
   endtask

   // ---------------- driver tasks (called at a negedge) ----------------
   task automatic idle(input int n);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_pixel(input logic [BD-1:0] d, input logic sof);
      int t;
      t = 0;
      in_data  = d;
      in_sof   = sof;
      in_valid = 1'b1;
      while (!in_ready && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) check("ready_timeout", 32'(t), 0);
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic send_range(input int base, input int first, input int last, input int duty);
      for (int i = first; i <= last; i++) begin
         if (duty < 100 && $urandom_range(0, 99) >= duty) idle($urandom_range(1, 3));
         send_pixel(16'(base + i), i == 0);
      end
   endtask

   task automatic wait_frame_done(input int exp_cnt);
      int t;
      t = 0;
      while (fdone_cnt < exp_cnt && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) check("frame_done_timeout", 32'(fdone_cnt), 32'(exp_cnt));
      idle(4);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int   duty;
      logic swap_en;
      int   exp_fswap;
      int   exp_gap_line;
      int   exp_gap_end;
   } vec_t;

   vec_t vecs[4];

   logic [31:0] outs;
   int          low;

   initial begin
      vecs[0] = '{duty: 100, swap_en: 1'b1, exp_fswap: 1, exp_gap_line: 3, exp_gap_end: 6};
      vecs[1] = '{duty: 100, swap_en: 1'b0, exp_fswap: 0, exp_gap_line: 3, exp_gap_end: 6};
      vecs[2] = '{duty: 50,  swap_en: 1'b1, exp_fswap: 1, exp_gap_line: 3, exp_gap_end: 6};
      vecs[3] = '{duty: 50,  swap_en: 1'b0, exp_fswap: 0, exp_gap_line: 3, exp_gap_end: 6};

      rst = 1'b1; in_data = '0; in_sof = 1'b0; in_valid = 1'b0;
      cfg_swap_en = 1'b1; wr_row_rdy = 1'b1;
      clear_mon();
      repeat (3) @(negedge clk);

      outs = 32'({wr_bank_addr, wr_row_addr, wr_row_store, wr_row_swap, wr_data,
                  wr_col_addr, wr_en, frame_swap, frame_done, err_sof});
      check("reset_outputs", outs, 0);
      check("reset_state", 32'(dbg_state), 0);
      check("reset_in_ready", 32'(in_ready), 1);
      rst = 1'b0;
      @(negedge clk);

      // Full frames: continuous and gapped valid, frame flip enabled and disabled.
      for (int k = 0; k < 4; k++) begin
         cfg_swap_en = vecs[k].swap_en;
         clear_mon();
         exp_frame(0, 0);
         send_range(0, 0, PIX - 1, vecs[k].duty);
         wait_frame_done(1);
         compare_all($sformatf("frame%0d", k));
         check($sformatf("frame%0d_swaps", k), 32'(swap_cnt), LINES);
         check($sformatf("frame%0d_frame_swap", k), 32'(fswap_cnt), 32'(vecs[k].exp_fswap));
         check($sformatf("frame%0d_frame_done", k), 32'(fdone_cnt), 1);
         check($sformatf("frame%0d_err_sof", k), 32'(err_cnt), 0);
         check($sformatf("frame%0d_gap_count", k), 32'(gap_q.size()), LINES);
         for (int g = 0; g < gap_q.size(); g++)
            check($sformatf("frame%0d_ready_gap", k), 32'(gap_q[g]),
                  32'((g == LINES - 1) ? vecs[k].exp_gap_end : vecs[k].exp_gap_line));
      end

      // Row-ready stall after line 0 with the next pixel held on the input.
      cfg_swap_en = 1'b1;
      clear_mon();
      exp_frame(16'h300, 0);
      wr_row_rdy = 1'b0;
      send_range(16'h300, 0, NC - 1, 100);
      in_data = 16'h300 + 16'(NC); in_sof = 1'b0; in_valid = 1'b1;
      low = 0;
      for (int i = 0; i < 20; i++) begin
         if (!in_ready) low++;
         @(negedge clk);
      end
      check("stall_ready_low", 32'(low), 20);
      check("stall_no_swap", 32'(swap_cnt), 0);
      check("stall_no_store", 32'(st_q.size()), 0);
      wr_row_rdy = 1'b1;
      @(negedge clk);
      check("stall_swap_after_rdy", 32'(wr_row_swap), 1);
      send_range(16'h300, NC, PIX - 1, 100);
      wait_frame_done(1);
      compare_all("stall");
      check("stall_frame_swap", 32'(fswap_cnt), 1);

      // Stray start-of-frame at col 5 of line 2 restarts the frame.
      clear_mon();
      for (int i = 0; i < 2 * NC + 5; i++) exp_q.push_back({3'(i % NC), 16'(16'h400 + i)});
      exp_st_q.push_back(3'd0);
      exp_st_q.push_back(3'd1);
      exp_q.push_back({3'd0, 16'h04AA});
      exp_frame(16'h500, 1);
      send_range(16'h400, 0, 2 * NC + 4, 100);
      send_pixel(16'h04AA, 1'b1);
      check("sof_err_pulse", 32'(err_sof), 1);
      check("sof_wr_en", 32'(wr_en), 1);
      check("sof_col_addr", 32'(wr_col_addr), 0);
      check("sof_wr_data", 32'(wr_data), 32'h04AA);
      send_range(16'h500, 1, PIX - 2, 100);
      check("sof_no_early_done", 32'(fdone_cnt), 0);
      send_range(16'h500, PIX - 1, PIX - 1, 100);
      wait_frame_done(1);
      compare_all("sof");
      check("sof_err_count", 32'(err_cnt), 1);
      check("sof_frame_swap", 32'(fswap_cnt), 1);

      // Reset in the middle of line 3, then a fresh frame.
      clear_mon();
      send_range(16'h600, 0, 3 * NC + 2, 100);
      check("rst_prior_stores", 32'(st_q.size()), 3);
      check("rst_prior_wr_en", 32'(wr_en), 1);
      #1 rst = 1'b1;
      #1;
      outs = 32'({wr_bank_addr, wr_row_addr, wr_row_store, wr_row_swap, wr_data,
                  wr_col_addr, wr_en, frame_swap, frame_done, err_sof});
      check("rst_async_outputs", outs, 0);
      check("rst_async_state", 32'(dbg_state), 0);
      @(negedge clk);
      rst = 1'b0;
      clear_mon();
      exp_frame(16'h700, 0);
      send_range(16'h700, 0, PIX - 1, 100);
      wait_frame_done(1);
      compare_all("post_rst");
      check("post_rst_frame_done", 32'(fdone_cnt), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      n_bad++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
